// File: rtl/control_unit_if.sv
// control_unit_if
//   Bundles the control unit's datapath-facing signals.
//   Host/datapath side (master) drives:
//     Opcode[5:0]  instr[15:10] of the current instruction
//     z            registered zero flag
//     start        leave IDLE (level)
//     step_mode    1 = single-step, 0 = free run
//     step         single-step request (rising edge executes one instruction)
//   Control unit side (slave) drives:
//     pc_we, s_inc, s_inm, we3, wez, Op[2:0]   datapath controls (Mealy)
//     step_ack     one-cycle pulse after a stepped instruction
//     halted       HALT executed
//     illegal      sticky illegal-opcode flag
//     busy         state is RUN
//     instr_count  retired-instruction counter
//     state_dbg    current FSM state, for observation only
interface control_unit_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       Opcode;
    logic             z;
    logic             start;
    logic             step_mode;
    logic             step;
    logic             pc_we;
    logic             s_inc;
    logic             s_inm;
    logic             we3;
    logic             wez;
    logic [2:0]       Op;
    logic             step_ack;
    logic             halted;
    logic             illegal;
    logic             busy;
    logic [CNT_W-1:0] instr_count;
    logic [1:0]       state_dbg;

    modport master (
        output Opcode, z, start, step_mode, step,
        input  pc_we, s_inc, s_inm, we3, wez, Op,
        input  step_ack, halted, illegal, busy, instr_count, state_dbg
    );

    modport slave (
        input  Opcode, z, start, step_mode, step,
        output pc_we, s_inc, s_inm, we3, wez, Op,
        output step_ack, halted, illegal, busy, instr_count, state_dbg
    );
endinterface

// File: rtl/control_unit.sv
// control_unit
//   Sequencing control unit for the 8-bit microcontroller datapath. Decodes
//   Opcode/z into datapath controls one instruction per cycle, with
//   run / halt / single-step sequencing, illegal-opcode detection and a
//   retired-instruction counter.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    control_unit_if.slave (see interface header for signal list)
//
//   Step handshake: `step` is a request level; its rising edge (step high
//   this cycle, low the previous cycle) while in STEP_WAIT with step_mode=1
//   executes exactly one instruction in that same cycle, and `step_ack`
//   pulses high for exactly the following cycle. Holding `step` high does
//   not repeat; it must drop for at least one cycle to re-arm.
module control_unit #(
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    control_unit_if.slave   bus
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_RUN       = 2'd1;
    localparam logic [1:0] S_STEP_WAIT = 2'd2;
    localparam logic [1:0] S_HALTED    = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             step_q;
    logic             step_edge;
    logic             exec;
    logic             is_alu;
    logic             is_li;
    logic             is_halt;
    logic             is_illegal;
    logic             step_ack_r;
    logic             halted_r;
    logic             illegal_r;
    logic             busy_r;
    logic [CNT_W-1:0] count_r;

    logic             pc_we_c;
    logic             s_inc_c;
    logic             s_inm_c;
    logic             we3_c;
    logic             wez_c;
    logic [2:0]       op_c;

    assign step_edge = bus.step & ~step_q;

    // Leaving STEP_WAIT for RUN (step_mode dropped) takes priority over a
    // step edge in the same cycle, so that edge is discarded.
    assign exec = (state == S_RUN) ||
                  ((state == S_STEP_WAIT) && bus.step_mode && step_edge);

    assign is_alu     = bus.Opcode[5];
    assign is_li      = (bus.Opcode[5:2] == 4'b0100);
    assign is_halt    = (bus.Opcode == 6'b000100);
    // Legal non-ALU, non-LI opcodes are exactly 000000..000100.
    assign is_illegal = !is_alu && !is_li && (bus.Opcode > 6'd4);

    always_comb begin
        pc_we_c = 1'b0;
        s_inc_c = 1'b0;
        s_inm_c = 1'b0;
        we3_c   = 1'b0;
        wez_c   = 1'b0;
        op_c    = 3'b000;
        if (exec) begin
            if (is_alu) begin
                op_c    = bus.Opcode[4:2];
                we3_c   = 1'b1;
                wez_c   = 1'b1;
                pc_we_c = 1'b1;
            end else if (is_li) begin
                we3_c   = 1'b1;
                s_inm_c = 1'b1;
                pc_we_c = 1'b1;
            end else begin
                case (bus.Opcode)
                    6'b000001: begin s_inc_c = 1'b1;    pc_we_c = 1'b1; end
                    6'b000010: begin s_inc_c = bus.z;   pc_we_c = 1'b1; end
                    6'b000011: begin s_inc_c = ~bus.z;  pc_we_c = 1'b1; end
                    6'b000100: pc_we_c = 1'b0;  // HALT: PC frozen
                    default:   pc_we_c = 1'b1;  // NOP and illegal
                endcase
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = bus.step_mode ? S_STEP_WAIT : S_RUN;
            end
            S_RUN: begin
                if (is_halt)            state_nxt = S_HALTED;
                else if (bus.step_mode) state_nxt = S_STEP_WAIT;
            end
            S_STEP_WAIT: begin
                if (!bus.step_mode)       state_nxt = S_RUN;
                else if (exec && is_halt) state_nxt = S_HALTED;
            end
            default: state_nxt = S_HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            step_q     <= 1'b0;
            step_ack_r <= 1'b0;
            halted_r   <= 1'b0;
            illegal_r  <= 1'b0;
            busy_r     <= 1'b0;
            count_r    <= '0;
        end else begin
            state      <= state_nxt;
            step_q     <= bus.step;
            step_ack_r <= exec && (state == S_STEP_WAIT);
            busy_r     <= (state_nxt == S_RUN);
            if (exec && is_halt)    halted_r  <= 1'b1;
            if (exec && is_illegal) illegal_r <= 1'b1;
            if (exec && !is_halt)   count_r   <= count_r + CNT_W'(1);
        end
    end

    assign bus.pc_we       = pc_we_c;
    assign bus.s_inc       = s_inc_c;
    assign bus.s_inm       = s_inm_c;
    assign bus.we3         = we3_c;
    assign bus.wez         = wez_c;
    assign bus.Op          = op_c;
    assign bus.step_ack    = step_ack_r;
    assign bus.halted      = halted_r;
    assign bus.illegal     = illegal_r;
    assign bus.busy        = busy_r;
    assign bus.instr_count = count_r;
    assign bus.state_dbg   = state;

endmodule
